hpdcache_victim_evict: RTL and testbench

- Allocation/eviction sequencer directly downstream of the victim selector.
- On a refill allocation request it reads the set's directory, pulses the selector's sel_victim input, and consumes the returned one-hot victim way.
- Issues a writeback request when the victim is valid and dirty, returns the allocated way to the miss handler, then pulses the selector's replacement-update interface.

---
 rtl/hpdcache_victim_evict_pkg.sv | 46 ++++
 rtl/hpdcache_victim_evict_if.sv | 57 +++++
 rtl/hpdcache_victim_evict.sv | 180 ++++++++++++++++++
 tb/tb_hpdcache_victim_evict.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_victim_evict_pkg.sv
// Shared configuration, types and helpers for the victim eviction sequencer.
// Optional feature macro: HPDCACHE_VICTIM_EVICT_STATS_EN (eviction counter).
package hpdcache_victim_evict_pkg;

    // Cache configuration: only the user geometry fields are needed here
    typedef struct packed {
        int unsigned ways;
        int unsigned sets;
    } hpdcache_user_cfg_t;

    typedef struct packed {
        hpdcache_user_cfg_t u;
    } hpdcache_cfg_t;

    localparam hpdcache_cfg_t HPDcacheCfg = '{u: '{ways: 4, sets: 64}};

    localparam int HPDCACHE_WAYS  = int'(HPDcacheCfg.u.ways);
    localparam int HPDCACHE_SET_W = (HPDcacheCfg.u.sets > 1) ? $clog2(HPDcacheCfg.u.sets) : 1;
    localparam int HPDCACHE_TAG_W = 20;

    typedef logic [HPDCACHE_SET_W-1:0]                    hpdcache_set_t;
    typedef logic [HPDCACHE_TAG_W-1:0]                    hpdcache_tag_t;
    typedef logic [HPDCACHE_WAYS-1:0]                     hpdcache_way_vector_t;
    typedef logic [HPDCACHE_WAYS-1:0][HPDCACHE_TAG_W-1:0] hpdcache_way_tags_t;

    // Writeback request presented on the evict_* outputs
    typedef struct packed {
        hpdcache_set_t        set;
        hpdcache_tag_t        tag;
        hpdcache_way_vector_t way;
    } hpdcache_evict_req_t;

    // One-hot tag mux: AND-OR so a zero select yields a zero tag
    function automatic hpdcache_tag_t hpdcache_mux_onehot_tag(
        input hpdcache_way_vector_t sel,
        input hpdcache_way_tags_t   tags
    );
        hpdcache_tag_t res;
        res = '0;
        for (int i = 0; i < HPDCACHE_WAYS; i++) begin
            res = res | (tags[i] & {HPDCACHE_TAG_W{sel[i]}});
        end
        return res;
    endfunction

endpackage

// File: rtl/hpdcache_victim_evict_if.sv
// Bundle of all allocation, directory, selector, replacement and eviction
// signals of the victim eviction sequencer. slave = sequencer side,
// master = surrounding cache (miss handler, directory, selector, writeback).
interface hpdcache_victim_evict_if;
    import hpdcache_victim_evict_pkg::*;

    logic                 alloc_req_valid_i;
    logic                 alloc_req_ready_o;
    hpdcache_set_t        alloc_req_set_i;
    logic                 alloc_rsp_valid_o;
    logic                 alloc_rsp_ready_i;
    logic                 alloc_rsp_ok_o;
    hpdcache_way_vector_t alloc_rsp_way_o;

    logic                 dir_rd_o;
    hpdcache_set_t        dir_rd_set_o;
    hpdcache_way_vector_t dir_valid_i;
    hpdcache_way_vector_t dir_dirty_i;
    hpdcache_way_vector_t dir_wback_i;
    hpdcache_way_vector_t dir_fetch_i;
    hpdcache_way_tags_t   dir_tags_i;

    logic                 sel_victim_o;
    hpdcache_way_vector_t sel_victim_way_i;

    logic                 repl_o;
    hpdcache_set_t        repl_set_o;
    hpdcache_way_vector_t repl_way_o;

    logic                 evict_valid_o;
    logic                 evict_ready_i;
    hpdcache_set_t        evict_set_o;
    hpdcache_tag_t        evict_tag_o;
    hpdcache_way_vector_t evict_way_o;
    logic [31:0]          evict_cnt_o;

    modport slave (
        input  alloc_req_valid_i, alloc_req_set_i, alloc_rsp_ready_i,
        input  dir_valid_i, dir_dirty_i, dir_wback_i, dir_fetch_i, dir_tags_i,
        input  sel_victim_way_i, evict_ready_i,
        output alloc_req_ready_o, alloc_rsp_valid_o, alloc_rsp_ok_o, alloc_rsp_way_o,
        output dir_rd_o, dir_rd_set_o, sel_victim_o,
        output repl_o, repl_set_o, repl_way_o,
        output evict_valid_o, evict_set_o, evict_tag_o, evict_way_o, evict_cnt_o
    );

    modport master (
        output alloc_req_valid_i, alloc_req_set_i, alloc_rsp_ready_i,
        output dir_valid_i, dir_dirty_i, dir_wback_i, dir_fetch_i, dir_tags_i,
        output sel_victim_way_i, evict_ready_i,
        input  alloc_req_ready_o, alloc_rsp_valid_o, alloc_rsp_ok_o, alloc_rsp_way_o,
        input  dir_rd_o, dir_rd_set_o, sel_victim_o,
        input  repl_o, repl_set_o, repl_way_o,
        input  evict_valid_o, evict_set_o, evict_tag_o, evict_way_o, evict_cnt_o
    );

endinterface

// File: rtl/hpdcache_victim_evict.sv
// Allocation/eviction sequencer sitting right after the victim selector:
// reads the set's directory, picks the victim, writes back a dirty line if
// needed, answers the miss handler and updates the replacement state.
// Optional feature macro: HPDCACHE_VICTIM_EVICT_STATS_EN (saturating
// 32-bit count of accepted writebacks on evict_cnt_o; tied to 0 otherwise).
module hpdcache_victim_evict
    import hpdcache_victim_evict_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    hpdcache_victim_evict_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIR   = 2'd1,
        EVICT = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e               state_q, state_d;
    hpdcache_set_t        set_q, set_d;
    hpdcache_way_vector_t way_q, way_d;
    hpdcache_tag_t        tag_q, tag_d;
    logic                 ok_q, ok_d;

    logic                 req_ready;
    logic                 req_fire;
    logic                 victim_busy;
    logic                 victim_need_evict;
    hpdcache_tag_t        victim_tag;
    hpdcache_evict_req_t  evict_req;

    // Request handshake; ready is masked by reset so nothing is taken while held
    assign req_ready = (state_q == IDLE) & ~rst_i;
    assign req_fire  = bus.alloc_req_valid_i & req_ready;

    // Victim properties, evaluated while the directory data is valid (DIR)
    assign victim_busy       = |(bus.sel_victim_way_i & bus.dir_fetch_i);
    assign victim_need_evict = |(bus.sel_victim_way_i & bus.dir_valid_i &
                                 bus.dir_dirty_i & bus.dir_wback_i);
    assign victim_tag        = hpdcache_mux_onehot_tag(bus.sel_victim_way_i, bus.dir_tags_i);

    assign evict_req = '{set: set_q, tag: tag_q, way: way_q};

    // State register and request context; asynchronous reset drops any request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            tag_q   <= '0;
            ok_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            way_q   <= way_d;
            tag_q   <= tag_d;
            ok_q    <= ok_d;
        end
    end

    // Next-state and context update
    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        way_d   = way_q;
        tag_d   = tag_q;
        ok_d    = ok_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    set_d   = bus.alloc_req_set_i;
                    state_d = DIR;
                end
            end
            DIR: begin
                way_d = bus.sel_victim_way_i;
                tag_d = victim_tag;
                // A line still being fetched cannot be replaced: ask for a retry
                if (victim_busy) begin
                    ok_d    = 1'b0;
                    state_d = RESP;
                end else if (victim_need_evict) begin
                    ok_d    = 1'b0;
                    state_d = EVICT;
                end else begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end
            end
            EVICT: begin
                if (bus.evict_ready_i) begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.alloc_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the current state; everything idles at zero
    always_comb begin
        bus.alloc_req_ready_o = req_ready;
        bus.dir_rd_o          = 1'b0;
        bus.dir_rd_set_o      = '0;
        bus.sel_victim_o      = 1'b0;
        bus.evict_valid_o     = 1'b0;
        bus.evict_set_o       = '0;
        bus.evict_tag_o       = '0;
        bus.evict_way_o       = '0;
        bus.alloc_rsp_valid_o = 1'b0;
        bus.alloc_rsp_ok_o    = 1'b0;
        bus.alloc_rsp_way_o   = '0;
        bus.repl_o            = 1'b0;
        bus.repl_set_o        = '0;
        bus.repl_way_o        = '0;
        case (state_q)
            IDLE: begin
                bus.dir_rd_o     = req_fire;
                bus.dir_rd_set_o = req_fire ? bus.alloc_req_set_i : '0;
            end
            DIR: begin
                bus.sel_victim_o = 1'b1;
            end
            EVICT: begin
                bus.evict_valid_o = 1'b1;
                bus.evict_set_o   = evict_req.set;
                bus.evict_tag_o   = evict_req.tag;
                bus.evict_way_o   = evict_req.way;
            end
            RESP: begin
                bus.alloc_rsp_valid_o = 1'b1;
                bus.alloc_rsp_ok_o    = ok_q;
                bus.alloc_rsp_way_o   = ok_q ? way_q : '0;
                // Replacement update only for a real allocation, on the handshake
                if (bus.alloc_rsp_ready_i && ok_q) begin
                    bus.repl_o     = 1'b1;
                    bus.repl_set_o = set_q;
                    bus.repl_way_o = way_q;
                end
            end
            default: ;
        endcase
    end

`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
    logic [31:0] evict_cnt_q, evict_cnt_d;
    logic        evict_fire;

    assign evict_fire = (state_q == EVICT) & bus.evict_ready_i;

    // Saturating count of accepted writeback requests
    always_comb begin
        evict_cnt_d = evict_cnt_q;
        if (evict_fire && (evict_cnt_q != 32'hFFFF_FFFF)) begin
            evict_cnt_d = evict_cnt_q + 32'd1;
        end
    end

    // Counter register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            evict_cnt_q <= '0;
        end else begin
            evict_cnt_q <= evict_cnt_d;
        end
    end

    assign bus.evict_cnt_o = evict_cnt_q;
`else
    assign bus.evict_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hpdcache_victim_evict.sv
// Directed testbench for hpdcache_victim_evict. Inputs change 2 time units
// after the rising edge; outputs are checked 1 unit later.
module tb_hpdcache_victim_evict;
    import hpdcache_victim_evict_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cnt_exp;

    hpdcache_victim_evict_if bus ();

    hpdcache_victim_evict dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Idle values on every bench-driven input
    task automatic idle_inputs();
        bus.alloc_req_valid_i = 1'b0;
        bus.alloc_req_set_i   = '0;
        bus.alloc_rsp_ready_i = 1'b1;
        bus.dir_valid_i       = '0;
        bus.dir_dirty_i       = '0;
        bus.dir_wback_i       = '0;
        bus.dir_fetch_i       = '0;
        bus.sel_victim_way_i  = '0;
        bus.evict_ready_i     = 1'b0;
        for (int i = 0; i < HPDCACHE_WAYS; i++) begin
            bus.dir_tags_i[i] = HPDCACHE_TAG_W'(32'h111 * (i + 1));
        end
    endtask

    // Present a request for one cycle and check it is taken with a directory read
    task automatic issue_req(input hpdcache_set_t set);
        bus.alloc_req_valid_i = 1'b1;
        bus.alloc_req_set_i   = set;
        #1;
        checks++;
        if (bus.alloc_req_ready_o !== 1'b1 || bus.dir_rd_o !== 1'b1 || bus.dir_rd_set_o !== set) begin
            failures++;
            $display("FAIL req_accept: ready=%b dir_rd=%b dir_rd_set=%0d, required 1 1 %0d",
                     bus.alloc_req_ready_o, bus.dir_rd_o, bus.dir_rd_set_o, set);
        end
        tick();
        bus.alloc_req_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.sel_victim_o !== 1'b1 || bus.alloc_req_ready_o !== 1'b0 || bus.dir_rd_o !== 1'b0) begin
            failures++;
            $display("FAIL dir_cycle: sel_victim=%b ready=%b dir_rd=%b, required 1 0 0",
                     bus.sel_victim_o, bus.alloc_req_ready_o, bus.dir_rd_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.alloc_req_valid_i = 1'b1;
        #3;
        checks++;
        if (bus.alloc_req_ready_o !== 1'b0 || bus.dir_rd_o !== 1'b0 || bus.alloc_rsp_valid_o !== 1'b0 ||
            bus.evict_valid_o !== 1'b0 || bus.repl_o !== 1'b0 || bus.sel_victim_o !== 1'b0 ||
            bus.evict_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b dir_rd=%b rsp_v=%b ev_v=%b repl=%b sel=%b cnt=%0d, required all 0",
                     bus.alloc_req_ready_o, bus.dir_rd_o, bus.alloc_rsp_valid_o, bus.evict_valid_o,
                     bus.repl_o, bus.sel_victim_o, bus.evict_cnt_o);
        end
        bus.alloc_req_valid_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cnt_exp = 0;
        #1;
        checks++;
        if (bus.alloc_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: got %b required 1", bus.alloc_req_ready_o);
        end
        $display("txn reset done");
    endtask

    task automatic test_clean();
        idle_inputs();
        bus.sel_victim_way_i = 4'b0001;
        issue_req(6'd5);
        tick();
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_ok_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b0001) begin
            failures++;
            $display("FAIL clean_rsp: valid=%b ok=%b way=%b, required 1 1 0001",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_ok_o, bus.alloc_rsp_way_o);
        end
        checks++;
        if (bus.repl_o !== 1'b1 || bus.repl_set_o !== 6'd5 || bus.repl_way_o !== 4'b0001 ||
            bus.evict_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL clean_repl: repl=%b set=%0d way=%b evict_valid=%b, required 1 5 0001 0",
                     bus.repl_o, bus.repl_set_o, bus.repl_way_o, bus.evict_valid_o);
        end
        tick();
        #1;
        checks++;
        if (bus.repl_o !== 1'b0 || bus.alloc_rsp_valid_o !== 1'b0 || bus.alloc_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL clean_after: repl=%b rsp_valid=%b ready=%b, required 0 0 1",
                     bus.repl_o, bus.alloc_rsp_valid_o, bus.alloc_req_ready_o);
        end
        $display("txn clean set=5 way=0001 done");
    endtask

    task automatic test_dirty_evict();
        idle_inputs();
        bus.sel_victim_way_i = 4'b0100;
        bus.dir_valid_i      = 4'b0100;
        bus.dir_dirty_i      = 4'b0100;
        bus.dir_wback_i      = 4'b0100;
        bus.dir_tags_i[2]    = 20'h0003A;
        issue_req(6'd9);
        tick();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (bus.evict_valid_o !== 1'b1 || bus.evict_set_o !== 6'd9 || bus.evict_tag_o !== 20'h0003A ||
                bus.evict_way_o !== 4'b0100 || bus.alloc_rsp_valid_o !== 1'b0) begin
                failures++;
                $display("FAIL evict_stall[%0d]: valid=%b set=%0d tag=%h way=%b rsp_valid=%b, required 1 9 0003a 0100 0",
                         c, bus.evict_valid_o, bus.evict_set_o, bus.evict_tag_o, bus.evict_way_o,
                         bus.alloc_rsp_valid_o);
            end
            tick();
        end
        bus.evict_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.evict_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL evict_accept_valid: got %b required 1", bus.evict_valid_o);
        end
        tick();
`ifdef HPDCACHE_VICTIM_EVICT_STATS_EN
        cnt_exp = cnt_exp + 1;
`endif
        bus.evict_ready_i = 1'b0;
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_ok_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b0100 ||
            bus.evict_valid_o !== 1'b0 || bus.repl_o !== 1'b1 || bus.repl_set_o !== 6'd9) begin
            failures++;
            $display("FAIL evict_rsp: valid=%b ok=%b way=%b ev_valid=%b repl=%b repl_set=%0d, required 1 1 0100 0 1 9",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_ok_o, bus.alloc_rsp_way_o, bus.evict_valid_o,
                     bus.repl_o, bus.repl_set_o);
        end
        checks++;
        if (bus.evict_cnt_o !== 32'(cnt_exp)) begin
            failures++;
            $display("FAIL evict_cnt: got %0d required %0d", bus.evict_cnt_o, cnt_exp);
        end
        tick();
        $display("txn dirty set=9 way=0100 tag=3a evicted");
    endtask

    task automatic test_busy();
        idle_inputs();
        bus.sel_victim_way_i = 4'b0010;
        bus.dir_fetch_i      = 4'b0010;
        bus.dir_valid_i      = 4'b0010;
        bus.dir_dirty_i      = 4'b0010;
        bus.dir_wback_i      = 4'b0010;
        issue_req(6'd12);
        tick();
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_ok_o !== 1'b0 || bus.alloc_rsp_way_o !== 4'b0000 ||
            bus.repl_o !== 1'b0 || bus.evict_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_rsp: valid=%b ok=%b way=%b repl=%b ev_valid=%b, required 1 0 0000 0 0",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_ok_o, bus.alloc_rsp_way_o, bus.repl_o,
                     bus.evict_valid_o);
        end
        tick();
        #1;
        checks++;
        if (bus.alloc_req_ready_o !== 1'b1 || bus.repl_o !== 1'b0) begin
            failures++;
            $display("FAIL busy_after: ready=%b repl=%b, required 1 0", bus.alloc_req_ready_o, bus.repl_o);
        end
        $display("txn busy set=12 retry");
    endtask

    task automatic test_write_through();
        idle_inputs();
        bus.sel_victim_way_i = 4'b1000;
        bus.dir_valid_i      = 4'b1000;
        bus.dir_dirty_i      = 4'b1000;
        bus.dir_wback_i      = 4'b0000;
        issue_req(6'd33);
        tick();
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_ok_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b1000 ||
            bus.evict_valid_o !== 1'b0 || bus.repl_o !== 1'b1 || bus.repl_way_o !== 4'b1000) begin
            failures++;
            $display("FAIL wt_rsp: valid=%b ok=%b way=%b ev_valid=%b repl=%b repl_way=%b, required 1 1 1000 0 1 1000",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_ok_o, bus.alloc_rsp_way_o, bus.evict_valid_o,
                     bus.repl_o, bus.repl_way_o);
        end
        tick();
        $display("txn write-through set=33 way=1000 no evict");
    endtask

    task automatic test_reset_mid_evict();
        idle_inputs();
        bus.sel_victim_way_i = 4'b0100;
        bus.dir_valid_i      = 4'b0100;
        bus.dir_dirty_i      = 4'b0100;
        bus.dir_wback_i      = 4'b0100;
        issue_req(6'd7);
        tick();
        #1;
        checks++;
        if (bus.evict_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL mid_evict_valid: got %b required 1", bus.evict_valid_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.evict_valid_o !== 1'b0 || bus.evict_way_o !== 4'b0000 || bus.evict_tag_o !== 20'h0 ||
            bus.evict_set_o !== 6'd0 || bus.alloc_rsp_valid_o !== 1'b0 || bus.alloc_req_ready_o !== 1'b0 ||
            bus.evict_cnt_o !== 32'd0) begin
            failures++;
            $display("FAIL async_reset: ev_valid=%b way=%b tag=%h set=%0d rsp_valid=%b ready=%b cnt=%0d, required all 0",
                     bus.evict_valid_o, bus.evict_way_o, bus.evict_tag_o, bus.evict_set_o,
                     bus.alloc_rsp_valid_o, bus.alloc_req_ready_o, bus.evict_cnt_o);
        end
        cnt_exp = 0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.alloc_req_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_ready: got %b required 1", bus.alloc_req_ready_o);
        end
        idle_inputs();
        bus.sel_victim_way_i = 4'b0010;
        issue_req(6'd20);
        tick();
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_ok_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b0010 ||
            bus.repl_set_o !== 6'd20) begin
            failures++;
            $display("FAIL post_reset_rsp: valid=%b ok=%b way=%b repl_set=%0d, required 1 1 0010 20",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_ok_o, bus.alloc_rsp_way_o, bus.repl_set_o);
        end
        tick();
        $display("txn reset-in-evict dropped, set=20 way=0010 done");
    endtask

    task automatic test_rsp_stall_back_to_back();
        idle_inputs();
        bus.sel_victim_way_i  = 4'b0001;
        bus.alloc_rsp_ready_i = 1'b0;
        issue_req(6'd63);
        tick();
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b0001 || bus.repl_o !== 1'b0 ||
                bus.alloc_req_ready_o !== 1'b0) begin
                failures++;
                $display("FAIL rsp_stall[%0d]: valid=%b way=%b repl=%b ready=%b, required 1 0001 0 0",
                         c, bus.alloc_rsp_valid_o, bus.alloc_rsp_way_o, bus.repl_o, bus.alloc_req_ready_o);
            end
            tick();
        end
        bus.alloc_rsp_ready_i = 1'b1;
        #1;
        checks++;
        if (bus.repl_o !== 1'b1 || bus.repl_set_o !== 6'd63 || bus.repl_way_o !== 4'b0001) begin
            failures++;
            $display("FAIL rsp_stall_repl: repl=%b set=%0d way=%b, required 1 63 0001",
                     bus.repl_o, bus.repl_set_o, bus.repl_way_o);
        end
        tick();
        $display("txn stalled rsp set=63 done");
        // Next request is taken in the very cycle after the handshake
        bus.sel_victim_way_i = 4'b1000;
        issue_req(6'd1);
        checks++;
        if (bus.repl_o !== 1'b0) begin
            failures++;
            $display("FAIL repl_single_pulse: got %b required 0", bus.repl_o);
        end
        tick();
        #1;
        checks++;
        if (bus.alloc_rsp_valid_o !== 1'b1 || bus.alloc_rsp_way_o !== 4'b1000 || bus.repl_set_o !== 6'd1) begin
            failures++;
            $display("FAIL back_to_back_rsp: valid=%b way=%b repl_set=%0d, required 1 1000 1",
                     bus.alloc_rsp_valid_o, bus.alloc_rsp_way_o, bus.repl_set_o);
        end
        tick();
        $display("txn back-to-back set=1 way=1000 done");
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cnt_exp  = 0;
        test_reset();
        test_clean();
        test_dirty_evict();
        test_busy();
        test_write_through();
        test_reset_mid_evict();
        test_rsp_stall_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
